// File: rtl/desync_delay_bank.sv
// desync_delay_bank: NCH-channel clock-synchronous matched-delay bank.
// Each channel delays its request level by a runtime-selectable tap
// (TAP0..TAP3 cycles). A new select is held pending and only applied while
// the channel's shift chain is quiet, so outp never glitches on a tap change.
// Optional per-channel transition counters are enabled by defining the
// macro DELAY_EVCNT_EN (adds port ev_cnt).
module desync_delay_bank #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned MAX_DELAY = 32,
  parameter int unsigned TAP0      = 14,
  parameter int unsigned TAP1      = 20,
  parameter int unsigned TAP2      = 24,
  parameter int unsigned TAP3      = 30,
  parameter logic [1:0]  RESET_SEL = 2'd3,
  parameter int unsigned CH_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    inp,
  output logic [NCH-1:0]    outp,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    sel_pending,
  output logic [2*NCH-1:0]  sel_active
`ifdef DELAY_EVCNT_EN
  ,
  output logic [16*NCH-1:0] ev_cnt
`endif
);

  localparam int unsigned IW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  // Chain bit index that feeds outp for a given select code.
  function automatic logic [IW-1:0] tap_idx(input logic [1:0] s);
    case (s)
      2'b00:   return IW'(TAP0 - 1);
      2'b01:   return IW'(TAP1 - 1);
      2'b10:   return IW'(TAP2 - 1);
      default: return IW'(TAP3 - 1);
    endcase
  endfunction

  logic [MAX_DELAY-1:0] r_chain  [NCH];
  logic [1:0]           r_pend   [NCH];
  logic [1:0]           r_active [NCH];
  logic [NCH-1:0]       r_outp;
  logic [NCH-1:0]       r_busy;
  logic [NCH-1:0]       r_pending;

  logic [NCH-1:0]       w_quiet;
  logic [NCH-1:0]       w_wr;
  logic [NCH-1:0]       w_apply;
  logic [NCH-1:0]       w_out_next;

  // Per-channel quiet detect, config decode, apply decision and next outp.
  always_comb begin
    w_quiet    = '0;
    w_wr       = '0;
    w_apply    = '0;
    w_out_next = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      w_quiet[c]    = (r_chain[c] == {MAX_DELAY{inp[c]}});
      // Channel indices >= NCH never match, so such writes are dropped.
      w_wr[c]       = cfg_we && (cfg_ch == CH_W'(c));
      // A write in the same cycle takes priority over applying the old pend.
      w_apply[c]    = w_quiet[c] && r_pending[c] && !w_wr[c];
      w_out_next[c] = r_chain[c][tap_idx(r_active[c])];
    end
  end

  // Shift chains, registered outputs, busy flags and select bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_chain[c]  <= '0;
        r_pend[c]   <= '0;
        r_active[c] <= RESET_SEL;
      end
      r_outp    <= '0;
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        r_chain[c] <= {r_chain[c][MAX_DELAY-2:0], inp[c]};
        r_outp[c]  <= w_out_next[c];
        r_busy[c]  <= !w_quiet[c];
        if (w_wr[c]) begin
          r_pend[c]    <= cfg_sel;
          r_pending[c] <= 1'b1;
        end else if (w_apply[c]) begin
          r_active[c]  <= r_pend[c];
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  // Pack per-channel state onto the flat output buses.
  always_comb begin
    sel_active = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sel_active[2*c +: 2] = r_active[c];
    end
  end

  assign outp        = r_outp;
  assign busy        = r_busy;
  assign sel_pending = r_pending;

`ifdef DELAY_EVCNT_EN
  logic [15:0] r_cnt [NCH];

  // Saturating outp transition counters, cleared when a new select applies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) r_cnt[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (w_apply[c])
          r_cnt[c] <= '0;
        else if ((w_out_next[c] != r_outp[c]) && (r_cnt[c] != '1))
          r_cnt[c] <= r_cnt[c] + 16'd1;
      end
    end
  end

  // Pack counters onto the flat ev_cnt bus.
  always_comb begin
    ev_cnt = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ev_cnt[16*c +: 16] = r_cnt[c];
    end
  end
`endif

endmodule

// File: tb/tb_desync_delay_bank.sv
// Self-checking bench for desync_delay_bank (NCH=4, CH_W=3 so that an
// out-of-range channel index can be driven). Define DELAY_EVCNT_EN to also
// exercise the transition counters.
module tb_desync_delay_bank;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CH_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    inp = '0;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_sel = '0;
  logic [NCH-1:0]    outp;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    sel_pending;
  logic [2*NCH-1:0]  sel_active;
`ifdef DELAY_EVCNT_EN
  logic [16*NCH-1:0] ev_cnt;
`endif

  desync_delay_bank #(
    .NCH       (NCH),
    .MAX_DELAY (32),
    .TAP0      (14),
    .TAP1      (20),
    .TAP2      (24),
    .TAP3      (30),
    .RESET_SEL (2'd3),
    .CH_W      (CH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inp         (inp),
    .outp        (outp),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_sel     (cfg_sel),
    .busy        (busy),
    .sel_pending (sel_pending),
    .sel_active  (sel_active)
`ifdef DELAY_EVCNT_EN
    ,
    .ev_cnt      (ev_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [1:0] sel);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_sel = sel;
    tick();
    cfg_we  = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;        // select code written to channel 1
    int         rise_tick;  // tick index (1 = edge sampling the input rise) where outp[1] rises
    int         width;      // expected high width of outp[1]
  } tap_vec_t;

  tap_vec_t tv [4];

  initial begin
    int k;
    int t;
    logic [63:0] trace;
    logic [63:0] expmask;
    logic seen_hi;
    logic glitch;
    logic stale;
    logic [NCH-1:0] hist [0:199];
    logic [NCH-1:0] exp_o;
    int taps [NCH];

    tv[0] = '{sel: 2'b00, rise_tick: 15, width: 3};
    tv[1] = '{sel: 2'b01, rise_tick: 21, width: 3};
    tv[2] = '{sel: 2'b10, rise_tick: 25, width: 3};
    tv[3] = '{sel: 2'b11, rise_tick: 31, width: 3};
    taps[0] = 14; taps[1] = 20; taps[2] = 24; taps[3] = 30;

    // Reset defaults
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    check("rst_outp", 64'(outp), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_pending", 64'(sel_pending), 64'h0);
    check("rst_sel_active", 64'(sel_active), 64'hFF);

    // Default tap 30 latency on channel 0
    idle(8);
    inp[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (outp[0]) begin k = i; break; end
    end
    check("rst_latency_ch0", 64'(k), 64'd31);
    inp[0] = 1'b0;
    idle(40);

    // Tap sweep on channel 1 from the vector table
    for (int r = 0; r < 4; r++) begin
      cfg_write(3'd1, tv[r].sel);
      check($sformatf("sweep%0d_pending", r), 64'(sel_pending[1]), 64'h1);
      tick();
      check($sformatf("sweep%0d_active", r), 64'(sel_active[3:2]), 64'(tv[r].sel));
      check($sformatf("sweep%0d_pending_clr", r), 64'(sel_pending[1]), 64'h0);
      expmask = '0;
      for (int b = 0; b < tv[r].width; b++) expmask[tv[r].rise_tick + b] = 1'b1;
      trace = '0;
      inp[1] = 1'b1;
      for (int i = 1; i <= 50; i++) begin
        tick();
        trace[i] = outp[1];
        if (i == 3) inp[1] = 1'b0;
      end
      check($sformatf("sweep%0d_trace", r), trace, expmask);
    end

    // Deferred apply on channel 2 (select 11 -> 00 while busy)
    inp[2] = 1'b1;
    t = 0;
    for (int i = 0; i < 5; i++) begin tick(); t++; end
    check("defer_busy", 64'(busy[2]), 64'h1);
    cfg_write(3'd2, 2'b00);
    t++;
    check("defer_pending", 64'(sel_pending[2]), 64'h1);
    check("defer_active_old", 64'(sel_active[5:4]), 64'h3);
    seen_hi = 1'b0;
    glitch  = 1'b0;
    while (sel_pending[2] && t < 80) begin
      tick();
      t++;
      if (outp[2]) seen_hi = 1'b1;
      else if (seen_hi) glitch = 1'b1;
    end
    check("defer_apply_tick", 64'(t), 64'd33);
    check("defer_active_new", 64'(sel_active[5:4]), 64'h0);
    check("defer_no_glitch", 64'(glitch), 64'h0);
    check("defer_outp_high", 64'(outp[2]), 64'h1);
    check("defer_busy_clr", 64'(busy[2]), 64'h0);
    inp[2] = 1'b0;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (!outp[2]) begin k = i; break; end
    end
    check("defer_new_latency", 64'(k), 64'd15);
    idle(40);

    // Collision: two writes on busy channel 0, last one wins
    inp[0] = 1'b1;
    idle(2);
    cfg_write(3'd0, 2'b01);
    cfg_write(3'd0, 2'b10);
    check("coll_active_old", 64'(sel_active[1:0]), 64'h3);
    k = 0;
    while (sel_pending[0] && k < 80) begin tick(); k++; end
    check("coll_pending_done", 64'(sel_pending[0]), 64'h0);
    check("coll_active_last", 64'(sel_active[1:0]), 64'h2);
    inp[0] = 1'b0;
    idle(40);

    // Out-of-range channel index is ignored
    cfg_write(3'd5, 2'b00);
    tick();
    check("oor_pending", 64'(sel_pending), 64'h0);
    check("oor_active", 64'(sel_active), 64'hCE);

    // Write and apply on the same cycle: the write wins
    cfg_write(3'd3, 2'b01);
    check("wwin_pending1", 64'(sel_pending[3]), 64'h1);
    cfg_write(3'd3, 2'b10);
    check("wwin_pending2", 64'(sel_pending[3]), 64'h1);
    check("wwin_active_hold", 64'(sel_active[7:6]), 64'h3);
    tick();
    check("wwin_active_new", 64'(sel_active[7:6]), 64'h2);
    check("wwin_pending_clr", 64'(sel_pending[3]), 64'h0);

    // Independence: four channels on four taps against a history reference
    cfg_write(3'd0, 2'b00);
    cfg_write(3'd1, 2'b01);
    cfg_write(3'd2, 2'b10);
    cfg_write(3'd3, 2'b11);
    idle(2);
    check("indep_sel_active", 64'(sel_active), 64'hE4);
    for (int s = 0; s < 200; s++) begin
      inp = NCH'($urandom);
      tick();
      hist[s] = inp;
      for (int c = 0; c < NCH; c++)
        exp_o[c] = (s >= taps[c]) ? hist[s - taps[c]][c] : 1'b0;
      check($sformatf("indep_t%0d", s), 64'(outp), 64'(exp_o));
    end

    // Reset mid-flight discards in-flight transitions
    rst_n = 1'b0;
    inp   = '0;
    tick();
    check("midrst_outp", 64'(outp), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_sel_active", 64'(sel_active), 64'hFF);
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (outp != '0) stale = 1'b1;
    end
    check("midrst_no_stale", 64'(stale), 64'h0);

`ifdef DELAY_EVCNT_EN
    // Transition counter on channel 3: 5 pulses -> 10 edges, cleared on apply
    for (int p = 0; p < 5; p++) begin
      inp[3] = 1'b1;
      idle(2);
      inp[3] = 1'b0;
      idle(3);
    end
    idle(40);
    check("evcnt_ch3", 64'(ev_cnt[63:48]), 64'd10);
    check("evcnt_ch0", 64'(ev_cnt[15:0]), 64'd0);
    cfg_write(3'd3, 2'b00);
    tick();
    check("evcnt_clear", 64'(ev_cnt[63:48]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/desync_delay_bank.md
Name: desync_delay_bank

Overview:
- Multi-channel, clock-synchronous programmable matched-delay bank for the desynchronised DLX control path.
- Generalises the fixed 4-tap inverter-chain delay element to NCH independent channels with per-channel runtime tap selection.
- Each channel delays every level transition of its request input by a selected number of clock cycles, taken from a 4-entry tap table.
- Tap changes are glitch-free: a new selection takes effect only when the channel has no transition in flight.

Parameters:
- NCH, 4: number of independent delay channels (1..16).
- MAX_DELAY, 32: shift-chain length per channel in cycles; must be >= every TAPn.
- TAP0, 14: delay in cycles for select code 2'b00.
- TAP1, 20: delay in cycles for select code 2'b01.
- TAP2, 24: delay in cycles for select code 2'b10.
- TAP3, 30: delay in cycles for select code 2'b11.
- RESET_SEL, 3: select code loaded into every channel at reset.
- CH_W, 2: width of cfg_ch; requires 2**CH_W >= NCH.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset, synchronous and active-low.
- inp  in  NCH  Per-channel request level inputs, sampled every clk.
- outp  out  NCH  Per-channel delayed request levels.
- cfg_we  in  1  Config write strobe, one cycle per write.
- cfg_ch  in  CH_W  Channel index for a config write.
- cfg_sel  in  2  New delay select code.
- busy  out  NCH  Channel has a transition in flight.
- sel_pending  out  NCH  Channel holds a config write not yet applied.
- sel_active  out  2*NCH  Currently applied select code per channel; channel c occupies bits [2c+1:2c].

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All shift chains cleared to 0.
  - outp=0, busy=0, sel_pending=0.
  - sel_active = RESET_SEL for every channel; pending registers cleared.
  - Reset mid-operation discards all in-flight transitions.
- Datapath, per channel c:
  - chain[c][0] <= inp[c]; chain[c][k] <= chain[c][k-1] for k=1..MAX_DELAY-1.
  - outp[c] is registered: outp[c] <= chain[c][TAPsel-1], where TAPsel is the tap for sel_active[c].
  - Latency: a change of inp[c] sampled at edge n appears on outp[c] after edge n+TAPsel, i.e. exactly TAPsel cycles.
  - Pulses of any width >= 1 cycle are preserved, with both edges shifted by TAPsel.
- Quiet condition:
  - Channel c is quiet when every chain[c] bit equals inp[c].
  - busy[c] = registered NOT quiet, so it lags by 1 cycle.
- Config:
  - A cfg_we with cfg_ch < NCH stores cfg_sel into pend[cfg_ch] and sets sel_pending[cfg_ch].
  - A write with cfg_ch >= NCH is ignored.
  - A second write before apply overwrites pend (last write wins).
- Apply:
  - On any cycle the channel is quiet and sel_pending is set: sel_active <= pend and sel_pending <= 0.
  - outp cannot glitch on apply, because all chain bits are equal at that point.
  - A write and an apply on the same cycle for the same channel: the write wins. pend takes the new value and sel_pending stays 1; the new value applies on the next quiet cycle.
  - A write to an already-quiet channel applies 1 cycle after the write.
  - A channel that toggles continuously never applies its pending value, by design. Upstream guarantees idle gaps >= MAX_DELAY cycles.
- Channels are fully independent; there is no arbitration between them.

Optional Feature:
- Macro: DELAY_EVCNT_EN.
- Defined:
  - Adds output ev_cnt, width 16*NCH.
  - One 16-bit counter per channel, incremented on every outp transition (either edge).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on any applied select change for that channel.
- Undefined:
  - The port and all counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset default: hold rst_n=0 for 2 cycles, then release -> outp=0, busy=0, sel_pending=0, every sel_active=2'b11. Raise inp[0] at cycle 10 -> outp[0] rises at cycle 40.
- Tap sweep: channel 1, write sel 00, 01, 10, 11 in turn, each while idle; pulse inp[1] high for 3 cycles -> outp[1] high for 3 cycles, starting 14, 20, 24 and 30 cycles after the input edge.
- Deferred apply: with channel 2 at sel 11, raise inp[2]; 5 cycles later write sel 00 -> sel_pending[2]=1 until the chain fills. Apply occurs 1 cycle after quiet (~cycle 31 after the edge), with no outp[2] glitch. The next edge is delayed 14 cycles.
- Collisions: write ch0 sel 01 and then sel 10 on consecutive busy cycles -> 2'b10 is applied. Write to cfg_ch=5 with NCH=4 -> no state change.
- Independence and reset: run all 4 channels with different taps and random inputs -> each output matches a per-channel reference delay. Assert rst_n=0 mid-flight -> all outputs go to 0 the next cycle and no stale edge emerges later.
- DELAY_EVCNT_EN: 5 input pulses on ch3 -> ev_cnt[63:48]=10. An applied select change clears the counter to 0. Build without the macro -> no ev_cnt port.
